// File: rtl/conv_pkg.sv
// Shared definitions for the 3x3 convolution pipeline.
// Contents:
//   PIX_W    - pixel width in bits
//   WIN_TAPS - taps in a 3x3 window
//   WIN_W    - packed window width (WIN_TAPS * PIX_W)
//   pixel_t  - one unsigned pixel
//   column_t - one window column, index 0 = top row, index 2 = bottom row
//   win_idx  - byte index of tap (r, c) inside a packed window
package conv_pkg;

    localparam int unsigned PIX_W    = 8;
    localparam int unsigned WIN_TAPS = 9;
    localparam int unsigned WIN_W    = WIN_TAPS * PIX_W;

    typedef logic [PIX_W-1:0]        pixel_t;
    typedef logic [2:0][PIX_W-1:0]   column_t;

    // r = 0 is the oldest row (top), c = 0 the oldest column (left).
    function automatic int unsigned win_idx(input int unsigned r, input int unsigned c);
        return r * 3 + c;
    endfunction

endpackage

// File: rtl/line_buffer_ram.sv
// One line of pixel storage for the window buffer.
// Single-port, asynchronous read, read-before-write: o_rdata always shows the
// contents at i_addr before any write performed on this clock edge.
// Ports:
//   clk     - clock
//   i_addr  - column address
//   i_we    - write enable
//   i_wdata - pixel to store at i_addr
//   o_rdata - pixel currently stored at i_addr
// Contents are intentionally not reset.
module line_buffer_ram
    import conv_pkg::*;
#(
    parameter int unsigned DEPTH = 32,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic [AW-1:0] i_addr,
    input  logic          i_we,
    input  pixel_t        i_wdata,
    output pixel_t        o_rdata
);

    pixel_t r_mem [DEPTH];

    assign o_rdata = r_mem[i_addr];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

endmodule

// File: rtl/conv_window_buffer.sv
// Raster-order pixel stream to packed 3x3 window converter.
// Buffers two lines, emits one window per accepted pixel at row>=2, col>=2.
// Ports:
//   clk, rst_n  - clock, synchronous active-low reset
//   in_valid    - pixel present on in_pixel
//   in_sof      - accepted pixel is frame position (0,0)
//   in_pixel    - unsigned pixel
//   in_ready    - pixel accepted this cycle when in_valid
//   win_valid   - window holds a valid neighbourhood
//   win_ready   - downstream consumes window this cycle
//   window      - packed window, byte r*3+c, r=0 top, c=0 left
//   frame_done  - one-cycle pulse after last pixel of a frame is accepted
module conv_window_buffer
    import conv_pkg::*;
#(
    parameter int unsigned IMG_W = 32,
    parameter int unsigned IMG_H = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             in_sof,
    input  logic [PIX_W-1:0] in_pixel,
    output logic             in_ready,
    output logic             win_valid,
    input  logic             win_ready,
    output logic [WIN_W-1:0] window,
    output logic             frame_done
);

    localparam int unsigned CW = $clog2(IMG_W);
    localparam int unsigned RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    logic [CW-1:0]    r_col;
    logic [RW-1:0]    r_row;
    logic             r_win_valid;
    logic [WIN_W-1:0] r_window;
    logic             r_frame_done;
    column_t          r_colbuf [2];   // [0] = left column, [1] = middle column

    logic             w_accept;
    logic [CW-1:0]    w_col;
    logic [RW-1:0]    w_row;
    pixel_t           w_lb0;
    pixel_t           w_lb1;
    column_t          w_new_col;
    logic             w_win_ok;
    logic [WIN_W-1:0] w_win;

    assign in_ready   = !r_win_valid || win_ready;
    assign w_accept   = in_valid && in_ready;

    // in_sof overrides the counters so a resync pixel lands at (0,0).
    assign w_col      = in_sof ? '0 : r_col;
    assign w_row      = in_sof ? '0 : r_row;
    assign w_win_ok   = (w_row >= RW'(2)) && (w_col >= CW'(2));

    assign win_valid  = r_win_valid;
    assign window     = r_window;
    assign frame_done = r_frame_done;

    line_buffer_ram #(.DEPTH(IMG_W), .AW(CW)) u_lb0 (
        .clk     (clk),
        .i_addr  (w_col),
        .i_we    (w_accept),
        .i_wdata (in_pixel),
        .o_rdata (w_lb0)
    );

    line_buffer_ram #(.DEPTH(IMG_W), .AW(CW)) u_lb1 (
        .clk     (clk),
        .i_addr  (w_col),
        .i_we    (w_accept),
        .i_wdata (w_lb0),
        .o_rdata (w_lb1)
    );

    // Top = two lines ago, middle = previous line, bottom = incoming pixel.
    assign w_new_col = {in_pixel, w_lb0, w_lb1};

    always_comb begin
        w_win = '0;
        for (int unsigned c = 0; c < 3; c++) begin
            for (int unsigned r = 0; r < 3; r++) begin
                if (c == 2) begin
                    w_win[win_idx(r, c)*PIX_W +: PIX_W] = w_new_col[r];
                end else begin
                    w_win[win_idx(r, c)*PIX_W +: PIX_W] = r_colbuf[c][r];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_col        <= '0;
            r_row        <= '0;
            r_win_valid  <= 1'b0;
            r_window     <= '0;
            r_frame_done <= 1'b0;
            r_colbuf[0]  <= '0;
            r_colbuf[1]  <= '0;
        end else begin
            r_frame_done <= w_accept && (w_row == ROW_LAST) && (w_col == COL_LAST);
            if (w_accept) begin
                r_colbuf[0] <= r_colbuf[1];
                r_colbuf[1] <= w_new_col;
                if (w_col == COL_LAST) begin
                    r_col <= '0;
                    r_row <= (w_row == ROW_LAST) ? '0 : w_row + RW'(1);
                end else begin
                    r_col <= w_col + CW'(1);
                    r_row <= w_row;
                end
                r_win_valid <= w_win_ok;
                if (w_win_ok) begin
                    r_window <= w_win;
                end
            end else if (win_ready) begin
                r_win_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_conv_window_buffer.sv
module tb_conv_window_buffer;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_sof;
    logic [7:0]  in_pixel;
    logic        in_ready;
    logic        win_valid;
    logic        win_ready;
    logic [71:0] window;
    logic        frame_done;

    int checks;
    int failures;

    conv_window_buffer #(.IMG_W(4), .IMG_H(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_sof     (in_sof),
        .in_pixel   (in_pixel),
        .in_ready   (in_ready),
        .win_valid  (win_valid),
        .win_ready  (win_ready),
        .window     (window),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [71:0] mk(input logic [7:0] a0, a1, a2, a3, a4, a5, a6, a7, a8);
        return {a8, a7, a6, a5, a4, a3, a2, a1, a0};
    endfunction

    // Window whose top-left tap is frame position (r0,c0); pixel(r,c) = base + r*4 + c + 1.
    function automatic logic [71:0] fwin(input int base, input int r0, input int c0);
        logic [71:0] w;
        w = '0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                w[(r*3+c)*8 +: 8] = 8'(base + (r0 + r) * 4 + (c0 + c) + 1);
        return w;
    endfunction

    // Present one pixel and return #1 after the edge on which it was accepted.
    task automatic push(input logic [7:0] p, input logic sof);
        int n;
        n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_pixel = p;
        in_sof   = sof;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("push_timeout", 72'(in_ready), 72'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    // Push a full 4x4 frame and check window/valid/frame_done after every pixel.
    task automatic run_frame(input string tag, input int base, input logic sof_first);
        int row, col;
        for (int k = 0; k < 16; k++) begin
            row = k / 4;
            col = k % 4;
            push(8'(base + k + 1), (k == 0) ? sof_first : 1'b0);
            chk({tag, "_valid"}, 72'(win_valid), 72'((row >= 2) && (col >= 2)));
            if ((row >= 2) && (col >= 2)) chk({tag, "_win"}, window, fwin(base, row - 2, col - 2));
            chk({tag, "_done"}, 72'(frame_done), 72'(k == 15));
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_sof    = 1'b0;
        in_pixel  = '0;
        win_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 72'(win_valid), 72'(0));
        chk("rst_window", window, 72'(0));
        chk("rst_done", 72'(frame_done), 72'(0));
        chk("rst_in_ready", 72'(in_ready), 72'(1));
        @(negedge clk);
        rst_n = 1'b1;

        // Frame 1 with backpressure on the first window
        for (int k = 1; k <= 10; k++) begin
            push(8'(k), k == 1);
            chk("f1_pre_valid", 72'(win_valid), 72'(0));
        end
        push(8'd11, 1'b0);
        chk("f1_w1_valid", 72'(win_valid), 72'(1));
        chk("f1_w1", window, mk(1, 2, 3, 5, 6, 7, 9, 10, 11));

        win_ready = 1'b0;
        in_valid  = 1'b1;
        in_pixel  = 8'd12;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("bp_in_ready", 72'(in_ready), 72'(0));
            chk("bp_valid", 72'(win_valid), 72'(1));
            chk("bp_window", window, mk(1, 2, 3, 5, 6, 7, 9, 10, 11));
        end
        win_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("f1_w2_valid", 72'(win_valid), 72'(1));
        chk("f1_w2", window, mk(2, 3, 4, 6, 7, 8, 10, 11, 12));

        // Line wrap: pixels 13,14 give no window
        push(8'd13, 1'b0);
        chk("wrap13_valid", 72'(win_valid), 72'(0));
        push(8'd14, 1'b0);
        chk("wrap14_valid", 72'(win_valid), 72'(0));
        push(8'd15, 1'b0);
        chk("f1_w3_valid", 72'(win_valid), 72'(1));
        chk("f1_w3", window, mk(5, 6, 7, 9, 10, 11, 13, 14, 15));
        chk("f1_done15", 72'(frame_done), 72'(0));
        push(8'd16, 1'b0);
        chk("f1_w4", window, mk(6, 7, 8, 10, 11, 12, 14, 15, 16));
        chk("f1_done", 72'(frame_done), 72'(1));
        @(posedge clk);
        #1;
        chk("f1_done_pulse", 72'(frame_done), 72'(0));
        chk("f1_idle_valid", 72'(win_valid), 72'(0));

        // Frame 2 follows from wrapped counters, no in_sof
        run_frame("f2", 0, 1'b0);

        // Resync: abandon after 6 pixels, in_sof on the 7th
        for (int k = 1; k <= 6; k++) begin
            push(8'(k), k == 1);
            chk("rs_pre_valid", 72'(win_valid), 72'(0));
        end
        run_frame("rs", 100, 1'b1);

        // Mid-frame reset after pixel 10
        for (int k = 1; k <= 10; k++) push(8'(k), k == 1);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("mr_valid", 72'(win_valid), 72'(0));
        chk("mr_window", window, 72'(0));
        chk("mr_done", 72'(frame_done), 72'(0));
        @(negedge clk);
        rst_n = 1'b1;
        run_frame("mr", 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
